// File: rtl/sat_pkg.sv
// Shared literal codes and clause-loader state encodings for the SAT literal-array datapath.
package sat_pkg;

    localparam logic [1:0] LIT_NONE = 2'b00;
    localparam logic [1:0] LIT_POS  = 2'b01;
    localparam logic [1:0] LIT_NEG  = 2'b10;
    localparam logic [1:0] LIT_RSVD = 2'b11;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'b00,
        LD_COLLECT = 2'b01,
        LD_WRITE   = 2'b10,
        LD_DONE    = 2'b11
    } ld_state_e;

endpackage

// File: rtl/lit_slot_buf.sv
// NUM_LITS x 2-bit slot register with clear, in-order indexed write and a saturating slot counter.
// row_nxt_o shows the packed row including any write happening this cycle (slot 0 in the MSB pair).
module lit_slot_buf
    import sat_pkg::*;
#(
    parameter int unsigned NUM_LITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [1:0]            lit_i,
    output logic [NUM_LITS*2-1:0] row_nxt_o,
    output logic                  ovf_o
);

    localparam int unsigned CNT_W = $clog2(NUM_LITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_LITS);

    logic [1:0]       slot_q [NUM_LITS];
    logic [CNT_W-1:0] cnt_q;

    assign ovf_o = wr_en_i && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            for (int unsigned i = 0; i < NUM_LITS; i++) begin
                slot_q[i] <= LIT_NONE;
            end
            cnt_q <= '0;
        end else if (wr_en_i && (cnt_q < CNT_MAX)) begin
            for (int unsigned i = 0; i < NUM_LITS; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    slot_q[i] <= lit_i;
                end
            end
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        row_nxt_o = '0;
        for (int unsigned i = 0; i < NUM_LITS; i++) begin
            row_nxt_o[NUM_LITS*2-1-2*i -: 2] = (wr_en_i && (cnt_q == CNT_W'(i))) ? lit_i : slot_q[i];
        end
    end

endmodule

// File: rtl/clause_loader.sv
// Packs a serial valid/ready stream of 2-bit literal codes into clause rows and writes NUM_CLAUSES
// rows per load. Define CLAUSE_LOADER_ERR_EN to enable the sticky err_o on reserved codes/overflow.
module clause_loader
    import sat_pkg::*;
#(
    parameter int unsigned NUM_LITS    = 8,
    parameter int unsigned NUM_CLAUSES = 16,
    parameter int unsigned CIDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [1:0]            in_lit_i,
    input  logic                  in_last_i,
    output logic                  wr_o,
    output logic [NUM_LITS*2-1:0] lit_o,
    output logic [CIDX_W-1:0]     clause_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NUM_CLAUSES - 1);

    ld_state_e             state_q;
    logic                  ready_q;
    logic                  wr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [CIDX_W-1:0]     idx_q;
    logic [NUM_LITS*2-1:0] lit_q;

    logic                  hs;
    logic                  buf_clr;
    logic                  ovf;
    logic                  err_beat;
    logic [1:0]            lit_wr;
    logic [NUM_LITS*2-1:0] row_nxt;

    assign hs      = in_valid_i & ready_q;
    assign buf_clr = ((state_q == LD_IDLE) && start_i) || (state_q == LD_WRITE);

`ifdef CLAUSE_LOADER_ERR_EN
    assign lit_wr   = (in_lit_i == LIT_RSVD) ? LIT_NONE : in_lit_i;
    assign err_beat = (in_lit_i == LIT_RSVD) || ovf;
`else
    assign lit_wr   = in_lit_i;
    // Overflow beats are dropped silently when error reporting is not built in.
    assign err_beat = ovf & 1'b0;
`endif

    lit_slot_buf #(
        .NUM_LITS (NUM_LITS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (buf_clr),
        .wr_en_i   (hs),
        .lit_i     (lit_wr),
        .row_nxt_o (row_nxt),
        .ovf_o     (ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LD_IDLE;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            lit_q   <= '0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (start_i) begin
                        state_q <= LD_COLLECT;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        lit_q   <= '0;
                    end
                end
                LD_COLLECT: begin
                    if (hs) begin
                        if (err_beat) begin
                            err_q <= 1'b1;
                        end
                        // The row captured here already includes the final beat being accepted.
                        if (in_last_i) begin
                            state_q <= LD_WRITE;
                            ready_q <= 1'b0;
                            wr_q    <= 1'b1;
                            lit_q   <= row_nxt;
                        end
                    end
                end
                LD_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= LD_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= LD_COLLECT;
                        ready_q <= 1'b1;
                        idx_q   <= idx_q + CIDX_W'(1);
                    end
                end
                LD_DONE: begin
                    state_q <= LD_IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= LD_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = ready_q;
    assign wr_o         = wr_q;
    assign lit_o        = lit_q;
    assign clause_idx_o = idx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
